// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - IO address map and seven-segment decode constants for io_bus_bridge
package io_map_pkg;

  localparam logic [19:0] IO_BASE_HI = 20'hFFFFF;

  // Byte offsets inside the 4 KiB IO window
  localparam logic [11:0] OFF_SEG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  // Word offsets: the low two address bits are ignored when decoding IO
  localparam logic [9:0] W_SEG   = OFF_SEG[11:2];
  localparam logic [9:0] W_TIMER = OFF_TIMER[11:2];
  localparam logic [9:0] W_LED   = OFF_LED[11:2];
  localparam logic [9:0] W_SW    = OFF_SW[11:2];
  localparam logic [9:0] W_BTN   = OFF_BTN[11:2];

  // Common-anode patterns {DP,G,F,E,D,C,B,A}, DP off; entry 15 first
  localparam logic [15:0][7:0] SEG7_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg7_decode(input logic [3:0] nib);
    return SEG7_LUT[nib];
  endfunction

endpackage

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed 8-digit seven-segment scan controller
module seg_scan
  import io_map_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] seg,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt;
  logic [2:0]    dig_idx;

  // Dwell counter; advances to the next digit (mod 8) when the dwell expires
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      scan_cnt <= '0;
      dig_idx  <= 3'd0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Enable and segment pattern registered together so a digit never shows its neighbour's pattern
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_en  <= 8'hFE;
      dig_seg <= 8'hC0;
    end else begin
      dig_en  <= ~(8'b1 << dig_idx);
      dig_seg <= seg7_decode(seg[{dig_idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/io_bus_bridge.sv
// rtl/io_bus_bridge.sv - CPU data-side decoder to DRAM and MMIO peripherals; IO_TIMER_EN adds a timer
module io_bus_bridge
  import io_map_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int SW_W      = 24,
  parameter int BTN_W     = 5,
  parameter int TIMER_DIV = 25000
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic [31:0]      addr_from_cpu,
  input  logic             we_from_cpu,
  input  logic [31:0]      wdata_from_cpu,
  output logic [31:0]      rdata_to_cpu,
  output logic [13:0]      dram_addr,
  output logic             dram_we,
  output logic [31:0]      dram_wdata,
  input  logic [31:0]      dram_rdata,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic [SW_W-1:0]  led,
  output logic [7:0]       dig_en,
  output logic [7:0]       dig_seg
);

  logic             is_io;
  logic [9:0]       io_word;
  logic             io_wr;
  logic [31:0]      seg_q;
  logic [SW_W-1:0]  sw_meta, sw_sync;
  logic [BTN_W-1:0] btn_meta, btn_sync;
  logic [1:0]       unused_addr_lsb;

  assign is_io           = (addr_from_cpu[31:12] == IO_BASE_HI);
  assign io_word         = addr_from_cpu[11:2];
  assign io_wr           = we_from_cpu & is_io;
  assign unused_addr_lsb = addr_from_cpu[1:0];

  assign dram_addr  = addr_from_cpu[15:2];
  assign dram_wdata = wdata_from_cpu;
  assign dram_we    = we_from_cpu & ~is_io;

  // Writable peripheral registers; reset wins over a same-cycle write
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      seg_q <= 32'h0;
      led   <= '0;
    end else if (io_wr) begin
      if (io_word == W_SEG) seg_q <= wdata_from_cpu;
      if (io_word == W_LED) led   <= wdata_from_cpu[SW_W-1:0];
    end
  end

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

`ifdef IO_TIMER_EN
  localparam int TW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [TW-1:0] PRE_MAX = TW'(TIMER_DIV - 1);

  logic [TW-1:0] presc;
  logic [31:0]   timer_q;

  // Free-running tick counter; a CPU write reloads it and restarts the prescaler
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      presc   <= '0;
      timer_q <= 32'h0;
    end else if (io_wr && io_word == W_TIMER) begin
      presc   <= '0;
      timer_q <= wdata_from_cpu;
    end else if (presc == PRE_MAX) begin
      presc   <= '0;
      timer_q <= timer_q + 32'd1;
    end else begin
      presc   <= presc + TW'(1);
    end
  end
`else
  localparam int unused_timer_div = TIMER_DIV;
`endif

  // Zero-latency read mux; unmapped IO words read as zero
  always_comb begin
    rdata_to_cpu = 32'h0;
    if (!is_io) begin
      rdata_to_cpu = dram_rdata;
    end else begin
      case (io_word)
        W_SEG:   rdata_to_cpu = seg_q;
        W_LED:   rdata_to_cpu = 32'(led);
        W_SW:    rdata_to_cpu = 32'(sw_sync);
        W_BTN:   rdata_to_cpu = 32'(btn_sync);
`ifdef IO_TIMER_EN
        W_TIMER: rdata_to_cpu = timer_q;
`endif
        default: rdata_to_cpu = 32'h0;
      endcase
    end
  end

  seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_seg_scan (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .seg     (seg_q),
    .dig_en  (dig_en),
    .dig_seg (dig_seg)
  );

endmodule

// File: tb/tb_io_bus_bridge.sv
// tb/tb_io_bus_bridge.sv - directed self-checking bench for io_bus_bridge (SCAN_DIV=4, TIMER_DIV=3)
module tb_io_bus_bridge;

  localparam int SW_W  = 24;
  localparam int BTN_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      addr;
  logic             we;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [13:0]      dram_addr;
  logic             dram_we;
  logic [31:0]      dram_wdata;
  logic [31:0]      dram_rdata;
  logic [SW_W-1:0]  sw;
  logic [BTN_W-1:0] btn;
  logic [SW_W-1:0]  led;
  logic [7:0]       dig_en;
  logic [7:0]       dig_seg;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [31:0] mem [16];
  logic [7:0]  exp_en  [8];
  logic [7:0]  exp_seg [8];

  always #5 clk = ~clk;

  io_bus_bridge #(
    .SCAN_DIV  (4),
    .SW_W      (SW_W),
    .BTN_W     (BTN_W),
    .TIMER_DIV (3)
  ) dut (
    .cpu_clk        (clk),
    .cpu_rst        (rst),
    .addr_from_cpu  (addr),
    .we_from_cpu    (we),
    .wdata_from_cpu (wdata),
    .rdata_to_cpu   (rdata),
    .dram_addr      (dram_addr),
    .dram_we        (dram_we),
    .dram_wdata     (dram_wdata),
    .dram_rdata     (dram_rdata),
    .sw             (sw),
    .btn            (btn),
    .led            (led),
    .dig_en         (dig_en),
    .dig_seg        (dig_seg)
  );

  // Small DRAM model: async read, write on the clock edge
  assign dram_rdata = (dram_addr < 14'd16) ? mem[dram_addr[3:0]] : 32'h0;
  always @(posedge clk) begin
    if (dram_we && dram_addr < 14'd16) mem[dram_addr[3:0]] <= dram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    exp_en  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    exp_seg = '{8'hC0, 8'h8E, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

    rst = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; sw = '0; btn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_dig_en", 32'(dig_en), 32'hFE);
    chk("rst_dig_seg", 32'(dig_seg), 32'hC0);
    rst = 1'b0;
    addr = 32'hFFFFF000; #1;
    chk("rst_seg_reg", rdata, 32'h0);

    // DRAM store then load
    addr = 32'h0000_0010; wdata = 32'h1234; we = 1'b1; #1;
    chk("dram_we_wr", 32'(dram_we), 32'h1);
    chk("dram_addr_wr", 32'(dram_addr), 32'h4);
    chk("dram_wdata_wr", dram_wdata, 32'h1234);
    step(); we = 1'b0; #1;
    chk("dram_rd", rdata, 32'h1234);
    chk("dram_led_idle", 32'(led), 32'h0);

    // LED write, aligned and misaligned read-back
    addr = 32'hFFFFF060; wdata = 32'h00ABCDEF; we = 1'b1; #1;
    chk("led_dram_we", 32'(dram_we), 32'h0);
    step(); we = 1'b0; #1;
    chk("led_out", 32'(led), 32'h00ABCDEF);
    chk("led_rd", rdata, 32'h00ABCDEF);
    addr = 32'hFFFFF063; #1;
    chk("led_rd_misaligned", rdata, 32'h00ABCDEF);

    // Synchroniser latency, with a dropped write to the RO switch register
    addr = 32'hFFFFF070; wdata = 32'hFFFFFFFF; we = 1'b1; sw = 24'h00F00F; btn = 5'h15; #1;
    chk("sw_n0", rdata, 32'h0);
    chk("ro_dram_we", 32'(dram_we), 32'h0);
    step(); we = 1'b0; #1;
    chk("sw_n1", rdata, 32'h0);
    step(); #1;
    chk("sw_n2", rdata, 32'h00F00F);
    addr = 32'hFFFFF078; #1;
    chk("btn_n2", rdata, 32'h15);
    addr = 32'hFFFFF010; #1;
    chk("dram_untouched", mem[4], 32'h1234);

`ifdef IO_TIMER_EN
    rst = 1'b1; step(); rst = 1'b0;
    addr = 32'hFFFFF020; #1;
    chk("timer_t0", rdata, 32'h0);
    step(); chk("timer_t1", rdata, 32'h0);
    step(); chk("timer_t2", rdata, 32'h0);
    step(); chk("timer_t3", rdata, 32'h1);
    step(); chk("timer_t4", rdata, 32'h1);
    step(); wdata = 32'd100; we = 1'b1;
    step(); we = 1'b0; #1;
    chk("timer_load", rdata, 32'd100);
    step(); chk("timer_l1", rdata, 32'd100);
    step(); chk("timer_l2", rdata, 32'd100);
    step(); chk("timer_l3", rdata, 32'd101);
`else
    addr = 32'hFFFFF020; wdata = 32'h55; we = 1'b1; #1;
    chk("timer_off_dram_we", 32'(dram_we), 32'h0);
    step(); we = 1'b0; #1;
    chk("timer_off_rd", rdata, 32'h0);
`endif

    // Scan sequence: after reset, m edges later digit ((m-1)/4)%8 is shown
    rst = 1'b1; step(); rst = 1'b0;
    addr = 32'hFFFFF000; wdata = 32'h876543F0; we = 1'b1;
    for (int m = 1; m <= 40; m++) begin
      step();
      if (m == 1) begin
        addr = 32'hFFFFF060; wdata = 32'h005A5A5A; we = 1'b1;
      end else begin
        we = 1'b0;
      end
      d = ((m - 1) / 4) % 8;
      chk($sformatf("scan_en_m%0d", m), 32'(dig_en), 32'(exp_en[d]));
      chk($sformatf("scan_seg_m%0d", m), 32'(dig_seg), 32'(exp_seg[d]));
    end
    chk("scan_led", 32'(led), 32'h005A5A5A);

    // Rewrite SEG while digit 5 is lit, then reset with dig_idx still 5
    for (int m = 41; m <= 53; m++) step();
    addr = 32'hFFFFF000; wdata = 32'h00A00000; we = 1'b1;
    step(); we = 1'b0;
    chk("live_en_m54", 32'(dig_en), 32'hDF);
    chk("live_seg_m54", 32'(dig_seg), 32'h82);
    step();
    chk("live_en_m55", 32'(dig_en), 32'hDF);
    chk("live_seg_m55", 32'(dig_seg), 32'h88);
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("midrst_en", 32'(dig_en), 32'hFE);
    chk("midrst_seg", 32'(dig_seg), 32'hC0);
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_seg_reg", rdata, 32'h0);

    // Unmapped IO write is dropped and reads zero
    addr = 32'hFFFFF100; wdata = 32'hDEADBEEF; we = 1'b1; #1;
    chk("unmapped_dram_we", 32'(dram_we), 32'h0);
    step(); we = 1'b0; #1;
    chk("unmapped_rd", rdata, 32'h0);
    repeat (3) step();
    chk("post_rst_en_r4", 32'(dig_en), 32'hFE);
    step();
    chk("post_rst_en_r5", 32'(dig_en), 32'hFD);
    chk("post_rst_seg_r5", 32'(dig_seg), 32'hC0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
